// File: rtl/execute_muldiv_ctrl.sv
// execute_muldiv_ctrl
// Iterative unsigned multiply/divide sequencer for the EX stage.
// It runs a 32-step shift-add multiply or a 32-step restoring divide.
// While the op runs it stalls the pipeline. The result is presented in
// the single cycle in which the instruction is released into EX/MEM.
//
// Ports
//   clk            pipeline clock, rising edge
//   rst            synchronous, active-low reset
//   MulDivE        EX instruction is a mul/div op (start request)
//   MulDivOpE      00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   SrcA_E         forwarded operand A (multiplicand / dividend)
//   SrcB_E         forwarded operand B (multiplier / divisor)
//   KillE          abort the EX instruction (trap / flush)
//   StallE         hold IF/ID/EX and the ID/EX register (combinational)
//   BusyE          registered, high while stepping
//   ResultValidE   registered, high in the release cycle only
//   MulDivResultE  registered result, held until the next completion
module execute_muldiv_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MulDivE,
  input  logic [1:0]      MulDivOpE,
  input  logic [XLEN-1:0] SrcA_E,
  input  logic [XLEN-1:0] SrcB_E,
  input  logic            KillE,
  output logic            StallE,
  output logic            BusyE,
  output logic            ResultValidE,
  output logic [XLEN-1:0] MulDivResultE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT             state;
  logic [5:0]        cnt;
  logic [1:0]        opReg;
  logic [XLEN-1:0]   aReg;
  logic [XLEN-1:0]   bReg;
  // Multiply: full 64-bit product accumulator.
  // Divide: {remainder, quotient}.
  logic [2*XLEN-1:0] acc;

  logic [4:0]        bitIdx;
  logic [XLEN:0]     mulSum;
  logic [2*XLEN-1:0] mulNext;
  logic [XLEN:0]     divShift;
  logic [XLEN+1:0]   divDiff;
  logic [2*XLEN-1:0] divNext;
  logic [2*XLEN-1:0] accNext;
  logic [XLEN-1:0]   stepResult;

  // One iteration of the selected algorithm.
  // Operands stay fixed in aReg/bReg. Instead of shifting them, the step
  // counter selects the multiplier bit (LSB first) and the dividend bit
  // (MSB first, hence the inverted index).
  always_comb begin
    bitIdx = cnt[4:0];

    // Add into the high half, keeping the carry, then shift {carry, acc} right.
    mulSum = {1'b0, acc[2*XLEN-1:XLEN]};
    if (bReg[bitIdx]) begin
      mulSum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, aReg};
    end
    mulNext = {mulSum, acc[XLEN-1:1]};

    // Shift the next dividend bit into a 33-bit remainder.
    // Then trial-subtract the divisor; the MSB of the difference is its sign.
    divShift = {acc[2*XLEN-1:XLEN], aReg[~bitIdx]};
    divDiff  = {1'b0, divShift} - {2'b00, bReg};
    if (!divDiff[XLEN+1]) begin
      divNext = {divDiff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      // Restore: the remainder stays below the divisor, so it fits in XLEN bits.
      divNext = {divShift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end

    accNext = opReg[1] ? divNext : mulNext;

    case (opReg)
      2'b00:   stepResult = accNext[XLEN-1:0];       // MUL: low product
      2'b01:   stepResult = accNext[2*XLEN-1:XLEN];  // MULHU: high product
      2'b10:   stepResult = accNext[XLEN-1:0];       // DIVU: quotient
      default: stepResult = accNext[2*XLEN-1:XLEN];  // REMU: remainder
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      opReg         <= '0;
      aReg          <= '0;
      bReg          <= '0;
      acc           <= '0;
      BusyE         <= 1'b0;
      ResultValidE  <= 1'b0;
      MulDivResultE <= '0;
    end else begin
      case (state)
        IDLE: begin
          ResultValidE <= 1'b0;
          if (MulDivE && !KillE) begin
            opReg <= MulDivOpE;
            aReg  <= SrcA_E;
            bReg  <= SrcB_E;
            acc   <= '0;
            cnt   <= '0;
            state <= BUSY;
            BusyE <= 1'b1;
          end
        end
        BUSY: begin
          if (KillE) begin
            // Abort: the result register keeps its previous value.
            state <= IDLE;
            BusyE <= 1'b0;
          end else begin
            acc <= accNext;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              state         <= DONE;
              BusyE         <= 1'b0;
              ResultValidE  <= 1'b1;
              MulDivResultE <= stepResult;
            end
          end
        end
        DONE: begin
          // Always return to IDLE, whatever MulDivE does. The released
          // instruction therefore cannot restart itself.
          state        <= IDLE;
          ResultValidE <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          BusyE        <= 1'b0;
          ResultValidE <= 1'b0;
        end
      endcase
    end
  end

  // Combinational, so the start cycle itself already stalls.
  assign StallE = rst & ~KillE & (((state == IDLE) & MulDivE) | (state == BUSY));

endmodule

// File: tb/tb_execute_muldiv_ctrl.sv
module tb_execute_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        MulDivE;
  logic [1:0]  MulDivOpE;
  logic [31:0] SrcA_E;
  logic [31:0] SrcB_E;
  logic        KillE;
  logic        StallE;
  logic        BusyE;
  logic        ResultValidE;
  logic [31:0] MulDivResultE;

  int nChecks = 0;
  int nFails  = 0;

  execute_muldiv_ctrl #(.XLEN(32)) dut (
    .clk(clk),
    .rst(rst),
    .MulDivE(MulDivE),
    .MulDivOpE(MulDivOpE),
    .SrcA_E(SrcA_E),
    .SrcB_E(SrcB_E),
    .KillE(KillE),
    .StallE(StallE),
    .BusyE(BusyE),
    .ResultValidE(ResultValidE),
    .MulDivResultE(MulDivResultE)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic for the four ops, from the ISA definitions.
  function automatic logic [31:0] golden(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Timeline model.
  // phase 0 = idle; 1..32 = the cycles after the start edge (busy);
  // 33 = the release cycle.
  int          mPhase = 0;
  logic [1:0]  mOp    = 2'b00;
  logic [31:0] mA     = 32'd0;
  logic [31:0] mB     = 32'd0;
  logic [31:0] mRes   = 32'd0;
  bit          mArmed = 1'b0;
  logic        cRst, cMd, cKill, expStall;
  logic [1:0]  cOp;
  logic [31:0] cA, cB;

  initial begin : compare
    forever begin
      @(negedge clk);
      cRst  = rst;
      cMd   = MulDivE;
      cKill = KillE;
      cOp   = MulDivOpE;
      cA    = SrcA_E;
      cB    = SrcB_E;
      if (mArmed) begin
        expStall = cRst && !cKill && ((mPhase == 0 && cMd) || (mPhase >= 1 && mPhase <= 32));
        check("model StallE", 32'(StallE), 32'(expStall));
        check("model BusyE", 32'(BusyE), 32'(mPhase >= 1 && mPhase <= 32));
        check("model ResultValidE", 32'(ResultValidE), 32'(mPhase == 33));
        check("model MulDivResultE", MulDivResultE, mRes);
      end
      @(posedge clk);
      if (!cRst) begin
        mPhase = 0;
        mRes   = 32'd0;
        mArmed = 1'b1;
      end else if (mArmed) begin
        if (cKill) begin
          mPhase = 0;
        end else if (mPhase == 0) begin
          if (cMd) begin
            mOp    = cOp;
            mA     = cA;
            mB     = cB;
            mPhase = 1;
          end
        end else if (mPhase < 32) begin
          mPhase = mPhase + 1;
        end else if (mPhase == 32) begin
          mPhase = 33;
          mRes   = golden(mOp, mA, mB);
        end else begin
          mPhase = 0;
        end
      end
    end
  end

  // Called 1ns after the edge that opens the start cycle T.
  // Returns 1ns into T+34.
  task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int stallCnt;
    stallCnt  = 0;
    MulDivE   = 1'b1;
    MulDivOpE = op;
    SrcA_E    = a;
    SrcB_E    = b;
    for (int i = 0; i < 33; i++) begin
      #3;
      if (StallE) stallCnt++;
      @(posedge clk);
      #1;
      if (i == 0) begin
        // Operands changing after the start edge must not matter.
        MulDivE   = 1'b0;
        MulDivOpE = ~op;
        SrcA_E    = ~a;
        SrcB_E    = 32'h5A5A_0003;
      end
    end
    check({name, " valid@T+33"}, 32'(ResultValidE), 32'd1);
    check({name, " result@T+33"}, MulDivResultE, exp);
    check({name, " stall@T+33"}, 32'(StallE), 32'd0);
    check({name, " stall cycles"}, 32'(stallCnt), 32'd33);
    @(posedge clk);
    #1;
    check({name, " busy@T+34"}, 32'(BusyE), 32'd0);
    check({name, " valid@T+34"}, 32'(ResultValidE), 32'd0);
  endtask

  initial begin : stimulus
    rst       = 1'b0;
    MulDivE   = 1'b0;
    MulDivOpE = 2'b00;
    SrcA_E    = 32'd0;
    SrcB_E    = 32'd0;
    KillE     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset StallE", 32'(StallE), 32'd0);
    check("reset BusyE", 32'(BusyE), 32'd0);
    check("reset ResultValidE", 32'(ResultValidE), 32'd0);
    check("reset MulDivResultE", MulDivResultE, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    runOp("MUL 7*6", 2'b00, 32'd7, 32'd6, 32'd42);
    runOp("MULHU ff*ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    runOp("MUL ff*ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    runOp("DIVU 100/7", 2'b10, 32'd100, 32'd7, 32'd14);
    runOp("REMU 100/7", 2'b11, 32'd100, 32'd7, 32'd2);
    runOp("DIVU 8000_0000/1", 2'b10, 32'h8000_0000, 32'd1, 32'h8000_0000);
    runOp("DIVU 5/0", 2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF);
    runOp("REMU 5/0", 2'b11, 32'd5, 32'd0, 32'd5);

    // Kill at T+10: no stall that cycle, idle afterwards, result unchanged.
    MulDivE   = 1'b1;
    MulDivOpE = 2'b00;
    SrcA_E    = 32'd3;
    SrcB_E    = 32'd3;
    @(posedge clk);
    #1;
    MulDivE = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    KillE = 1'b1;
    #1;
    check("kill StallE@T+10", 32'(StallE), 32'd0);
    @(posedge clk);
    #1;
    KillE = 1'b0;
    check("kill BusyE@T+11", 32'(BusyE), 32'd0);
    check("kill StallE@T+11", 32'(StallE), 32'd0);
    repeat (30) begin
      @(posedge clk);
      #1;
    end
    check("kill result kept", MulDivResultE, 32'd5);
    check("kill no valid", 32'(ResultValidE), 32'd0);

    // Reset at T+20 of a divide: every output is zero in the next cycle.
    MulDivE   = 1'b1;
    MulDivOpE = 2'b10;
    SrcA_E    = 32'd100;
    SrcB_E    = 32'd7;
    @(posedge clk);
    #1;
    MulDivE = 1'b0;
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    check("rst StallE@T+20", 32'(StallE), 32'd0);
    @(posedge clk);
    #1;
    check("rst BusyE", 32'(BusyE), 32'd0);
    check("rst ResultValidE", 32'(ResultValidE), 32'd0);
    check("rst MulDivResultE", MulDivResultE, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // MulDivE held through DONE: a single completion, then a restart at T+34.
    MulDivE   = 1'b1;
    MulDivOpE = 2'b00;
    SrcA_E    = 32'd9;
    SrcB_E    = 32'd9;
    repeat (33) begin
      @(posedge clk);
      #1;
    end
    check("hold valid@T+33", 32'(ResultValidE), 32'd1);
    check("hold result@T+33", MulDivResultE, 32'd81);
    check("hold stall@T+33", 32'(StallE), 32'd0);
    @(posedge clk);
    #1;
    check("hold busy@T+34", 32'(BusyE), 32'd0);
    check("hold restart stall@T+34", 32'(StallE), 32'd1);
    @(posedge clk);
    #1;
    MulDivE = 1'b0;
    check("hold busy@T+35", 32'(BusyE), 32'd1);
    repeat (32) begin
      @(posedge clk);
      #1;
    end
    check("hold 2nd valid", 32'(ResultValidE), 32'd1);
    check("hold 2nd result", MulDivResultE, 32'd81);
    repeat (3) begin
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
